// File: rtl/bus_select_arb_pkg.sv
// Shared constants for the bus selector: arbitration mode codes, default
// geometry, and the pointer wrap helper.
package select_pkg;

   localparam int SEL_FIXED = 0;
   localparam int SEL_RR    = 1;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NCH   = 4;

   // Next channel index after idx, wrapping from n-1 back to 0.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bus_select_arb_if.sv
// Producer and consumer handshake bundle of the bus selector.
//
// Handshake rules:
//   producer side : channel k holds req[k] and its d_in slice stable until it
//                   sees gnt[k]; the word moves on the rising edge where
//                   req[k] & gnt[k]. gnt is combinational and one-hot.
//   consumer side : out_valid stays high with a stable word until the rising
//                   edge where out_valid & out_ready; out_valid never drops
//                   without that edge (except reset).
interface bus_select_arb_if #(
   parameter int WIDTH = select_pkg::DEF_WIDTH,
   parameter int NCH   = select_pkg::DEF_NCH
);
   localparam int SELW = $clog2(NCH);

   logic [NCH*WIDTH-1:0] d_in;
   logic [NCH-1:0]       req;
   logic [NCH-1:0]       gnt;
   logic [SELW-1:0]      sel;
   logic                 oe_n;
   logic                 out_valid;
   logic                 out_ready;

   modport slave (
      input  d_in, req, sel, oe_n, out_ready,
      output gnt, out_valid
   );

   modport master (
      output d_in, req, sel, oe_n, out_ready,
      input  gnt, out_valid
   );

endinterface

// File: rtl/bus_select_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping past NCH-1 to 0. en=0 suppresses any grant.
module rr_arbiter #(
   parameter int NCH  = 4,
   parameter int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  logic            en,
   output logic [NCH-1:0]  gnt,
   output logic [SELW-1:0] idx
);

   localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

   logic [SELW:0] k;
   logic          found;

   // Scan ptr, ptr+1, ... modulo NCH and grant the first active request.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < NCH; i++) begin
         k = {1'b0, ptr} + (SELW + 1)'(i);
         if (k >= NCH_W) k = k - NCH_W;
         if (en && !found && req[k[SELW-1:0]]) begin
            found              = 1'b1;
            gnt[k[SELW-1:0]]   = 1'b1;
            idx                = k[SELW-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_select_arb.sv
// N-channel selector: arbitrates one requester per transfer, registers the
// winning word with a valid/ready output stage, and drives it onto a shared
// tri-state bus under an active-low output enable.
module bus_select_arb
   import select_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NCH     = DEF_NCH,
   parameter int RR_MODE = SEL_RR,
   parameter int SELW    = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   bus_select_arb_if.slave  bus,
   output wire  [WIDTH-1:0] d_out,
   output logic [SELW-1:0]  dbg_ptr
);

   logic [WIDTH-1:0] dq;
   logic             out_valid_q;
   logic [SELW-1:0]  ptr;

   logic             accept;
   logic             en;
   logic [NCH-1:0]   arb_gnt;
   logic [NCH-1:0]   fix_gnt;
   logic [NCH-1:0]   gnt;
   logic [SELW-1:0]  arb_idx;
   logic [SELW-1:0]  win_idx;
   logic             xfer;
   logic [WIDTH-1:0] win_word;

   // A new word may enter when the register is empty or drains this edge;
   // reset also blocks every grant.
   assign accept = !out_valid_q || bus.out_ready;
   assign en     = rst_n && accept;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req (bus.req),
      .ptr (ptr),
      .en  (en && (RR_MODE == SEL_RR)),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Fixed-select decode: only the channel named by sel can win; an
   // out-of-range sel grants nothing.
   always_comb begin
      fix_gnt = '0;
      if (en && (int'(bus.sel) < NCH) && bus.req[bus.sel]) fix_gnt[bus.sel] = 1'b1;
   end

   // Pick the grant vector and winner index of the configured mode.
   always_comb begin
      if (RR_MODE == SEL_RR) begin
         gnt     = arb_gnt;
         win_idx = arb_idx;
      end else begin
         gnt     = fix_gnt;
         win_idx = bus.sel;
      end
   end

   assign bus.gnt  = gnt;
   assign xfer     = |(bus.req & gnt);
   assign win_word = bus.d_in[win_idx*WIDTH +: WIDTH];

   // Output register and round-robin pointer; a new word beats a drain on
   // the same edge so the stage sustains one word per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dq          <= '0;
         out_valid_q <= 1'b0;
         ptr         <= '0;
      end else if (xfer) begin
         dq          <= win_word;
         out_valid_q <= 1'b1;
         if (RR_MODE == SEL_RR) ptr <= SELW'(wrap_inc(int'(win_idx), NCH));
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign d_out         = bus.oe_n ? {WIDTH{1'bz}} : dq;
   assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_bus_select_arb.sv
// Bench for bus_select_arb: one round-robin and one fixed-select instance
// share the same producers and consumer, each tracked by its own
// behavioural model, plus an expected-word queue on the round-robin output.
module tb_bus_select_arb;
   import select_pkg::*;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus signals ----------------
   logic [NCH-1:0]       req;
   logic [WIDTH-1:0]     din [NCH];
   logic [NCH*WIDTH-1:0] din_p;
   logic [SELW-1:0]      sel;
   logic                 oe_n;
   logic                 out_ready;

   always_comb begin
      din_p = '0;
      for (int k = 0; k < NCH; k++) din_p[k*WIDTH +: WIDTH] = din[k];
   end

   bus_select_arb_if #(.WIDTH(WIDTH), .NCH(NCH)) rr_if ();
   bus_select_arb_if #(.WIDTH(WIDTH), .NCH(NCH)) fx_if ();

   assign rr_if.d_in      = din_p;
   assign rr_if.req       = req;
   assign rr_if.sel       = '0;
   assign rr_if.oe_n      = oe_n;
   assign rr_if.out_ready = out_ready;

   assign fx_if.d_in      = din_p;
   assign fx_if.req       = req;
   assign fx_if.sel       = sel;
   assign fx_if.oe_n      = oe_n;
   assign fx_if.out_ready = out_ready;

   wire  [WIDTH-1:0] rr_dout;
   wire  [WIDTH-1:0] fx_dout;
   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  fx_ptr;

   bus_select_arb #(.WIDTH(WIDTH), .NCH(NCH), .RR_MODE(SEL_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(rr_if), .d_out(rr_dout), .dbg_ptr(rr_ptr)
   );

   bus_select_arb #(.WIDTH(WIDTH), .NCH(NCH), .RR_MODE(SEL_FIXED)) u_fx (
      .clk(clk), .rst_n(rst_n), .bus(fx_if), .d_out(fx_dout), .dbg_ptr(fx_ptr)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int               r_ptr;
   bit               r_valid;
   logic [WIDTH-1:0] r_dq;
   bit               f_valid;
   logic [WIDTH-1:0] f_dq;

   function automatic int rr_pick();
      if (!rst_n || (r_valid && !out_ready)) return -1;
      for (int i = 0; i < NCH; i++)
         if (req[(r_ptr + i) % NCH]) return (r_ptr + i) % NCH;
      return -1;
   endfunction

   function automatic int fx_pick();
      if (!rst_n || (f_valid && !out_ready)) return -1;
      if (int'(sel) < NCH && req[sel]) return int'(sel);
      return -1;
   endfunction

   function automatic logic [NCH-1:0] onehot(input int idx);
      logic [NCH-1:0] v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge with inputs already applied: checks the
   // DUTs against the model, then advances the model across the rising edge.
   task automatic cycle();
      int wr;
      int wf;
      logic [WIDTH-1:0] w;
      #1;
      wr = rr_pick();
      wf = fx_pick();
      check_val("rr_gnt",   rr_if.gnt, onehot(wr));
      check_val("fx_gnt",   fx_if.gnt, onehot(wf));
      check_val("rr_valid", rr_if.out_valid, r_valid);
      check_val("fx_valid", fx_if.out_valid, f_valid);
      check_val("rr_ptr",   rr_ptr, r_ptr);
      check_val("fx_ptr",   fx_ptr, 0);
      if (!oe_n) begin
         check_val("rr_dout", rr_dout, r_dq);
         check_val("fx_dout", fx_dout, f_dq);
      end
      if (rst_n && rr_if.out_valid && out_ready) begin
         check_val("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            if (!oe_n) check_val("sb_word", rr_dout, w);
         end
      end
      @(posedge clk);
      if (!rst_n) begin
         r_ptr   = 0;
         r_valid = 0;
         r_dq    = '0;
         f_valid = 0;
         f_dq    = '0;
         exp_q.delete();
      end else begin
         if (wr >= 0) begin
            r_dq    = din[wr];
            r_valid = 1;
            r_ptr   = (wr + 1) % NCH;
            exp_q.push_back(din[wr]);
         end else if (out_ready) begin
            r_valid = 0;
         end
         if (wf >= 0) begin
            f_dq    = din[wf];
            f_valid = 1;
         end else if (out_ready) begin
            f_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n     = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      oe_n      = 1'b0;
      sel       = 2'd2;
      din       = '{8'h11, 8'h22, 8'h33, 8'h44};
      r_ptr = 0; r_valid = 0; r_dq = '0; f_valid = 0; f_dq = '0;
      @(posedge clk);
      @(negedge clk);

      // Reset held for two cycles with every channel requesting.
      #1;
      check_val("rst_gnt_rr", rr_if.gnt, 0);
      check_val("rst_gnt_fx", fx_if.gnt, 0);
      check_val("rst_valid",  rr_if.out_valid, 0);
      check_val("rst_dout",   rr_dout, 8'h00);
      cycle();
      oe_n = 1'b1;
      cycle();

      // Round-robin rotation.
      rst_n = 1'b1;
      oe_n  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_val("rot_gnt", rr_if.gnt, 4'b0001 << (i % 4));
         if (i > 0) check_val("rot_dout", rr_dout, din[(i - 1) % 4]);
         cycle();
      end
      #1;
      check_val("rot_dout_last", rr_dout, 8'h11);

      // Wrap and sparse requests: steer ptr to 3 first.
      req = 4'b0100;
      cycle();
      #1;
      check_val("wrap_ptr3", rr_ptr, 3);
      req = 4'b0101;
      #1;
      check_val("wrap_gnt", rr_if.gnt, 4'b0001);
      cycle();
      #1;
      check_val("wrap_ptr1", rr_ptr, 1);
      check_val("wrap_next_gnt", rr_if.gnt, 4'b0100);
      cycle();

      // Backpressure: load 8'h22 then stall with channel 3 waiting.
      req = 4'b0010;
      cycle();
      out_ready = 1'b0;
      req       = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("bp_gnt",  rr_if.gnt, 0);
         check_val("bp_dout", rr_dout, 8'h22);
         cycle();
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_release_gnt", rr_if.gnt, 4'b1000);
      cycle();
      #1;
      check_val("bp_new_dout",  rr_dout, 8'h44);
      check_val("bp_new_valid", rr_if.out_valid, 1);

      // Fixed mode: sel=2 then sel=3 with channels 0..2 requesting.
      sel = 2'd2;
      req = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("fx_sel2_gnt", fx_if.gnt, 4'b0100);
         cycle();
      end
      #1;
      check_val("fx_sel2_dout", fx_dout, 8'h33);
      sel = 2'd3;
      #1;
      check_val("fx_sel3_gnt", fx_if.gnt, 0);
      cycle();
      #1;
      check_val("fx_sel3_valid", fx_if.out_valid, 0);

      // Reset during a stall discards the held word.
      req = 4'b0001;
      cycle();
      out_ready = 1'b0;
      cycle();
      #1;
      check_val("ms_valid_before", rr_if.out_valid, 1);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
      check_val("ms_valid", rr_if.out_valid, 0);
      check_val("ms_dout",  rr_dout, 8'h00);
      check_val("ms_ptr",   rr_ptr, 0);
      cycle();

      // Randomized traffic, including bus release, sel changes and resets.
      for (int n = 0; n < 400; n++) begin
         req       = NCH'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         oe_n      = ($urandom_range(0, 7) == 0);
         rst_n     = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, 3));
         for (int k = 0; k < NCH; k++) din[k] = WIDTH'($urandom_range(0, 255));
         cycle();
      end
      rst_n = 1'b1;
      oe_n  = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
